// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory image loader.
package imem_loader_pkg;

   // Loader session states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_HI = 3'd1,
      ST_LEN_LO = 3'd2,
      ST_DATA   = 3'd3,
      ST_CSUM   = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERR    = 3'd6
   } state_t;

   // Framing: two length bytes ahead of the image, one checksum byte after it
   localparam int unsigned HDR_LEN    = 2;
   localparam int unsigned CSUM_LEN   = 1;
   // Image must hold whole 32-bit instructions
   localparam int unsigned INSN_BYTES = 4;

   // States in which a session is actively consuming host bytes
   function automatic logic is_busy(input state_t s);
      return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/imem_loader.sv
// Loads a length-prefixed, checksummed byte image into instruction memory
// while holding the CPU; bytes land at ascending addresses in arrival order.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 256
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_byte,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // One spare bit so a full-depth image never wraps the counter back to 0
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned LEN_W = 16;

   state_t             state;
   state_t             state_nx;
   logic [7:0]         len_hi;
   logic [LEN_W-1:0]   len;
   logic [LEN_W-1:0]   len_in;
   logic [CNT_W-1:0]   addr_cnt;
   logic [7:0]         acc;
   logic               accept;
   logic               len_ok;
   logic               last_byte;
   logic               idle_like;

   // Handshake, header decode and next-state selection
   always_comb begin
      state_nx  = state;
      accept    = in_valid && in_ready;
      len_in    = {len_hi, in_byte};
      len_ok    = (len_in != '0)
               && ((len_in % LEN_W'(INSN_BYTES)) == '0)
               && (32'(len_in) <= 32'(DEPTH));
      last_byte = ((LEN_W'(addr_cnt) + LEN_W'(1)) == len);
      idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);

      case (state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) state_nx = ST_LEN_HI;
         end
         ST_LEN_HI: begin
            if (accept) state_nx = ST_LEN_LO;
         end
         ST_LEN_LO: begin
            if (accept) state_nx = len_ok ? ST_DATA : ST_ERR;
         end
         ST_DATA: begin
            if (accept && last_byte) state_nx = ST_CSUM;
         end
         ST_CSUM: begin
            if (accept) state_nx = (8'(acc + in_byte) == 8'd0) ? ST_DONE : ST_ERR;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // State register, datapath registers and registered outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         len_hi   <= '0;
         len      <= '0;
         addr_cnt <= '0;
         acc      <= '0;
         in_ready <= 1'b0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         cpu_hold <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_nx;
         wr_en    <= 1'b0;

         // Status outputs follow the state being entered
         in_ready <= is_busy(state_nx);
         busy     <= is_busy(state_nx);
         cpu_hold <= (state_nx != ST_IDLE) && (state_nx != ST_DONE);
         done     <= (state_nx == ST_DONE);
         err      <= (state_nx == ST_ERR);

         if (idle_like && start) begin
            addr_cnt <= '0;
            acc      <= '0;
         end

         if (state == ST_LEN_HI && accept) len_hi <= in_byte;
         if (state == ST_LEN_LO && accept) len    <= len_in;

         if (state == ST_DATA && accept) begin
            wr_en    <= 1'b1;
            wr_addr  <= addr_cnt[ADDR_W-1:0];
            wr_data  <= in_byte;
            addr_cnt <= addr_cnt + CNT_W'(1);
            acc      <= 8'(acc + in_byte);
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for the instruction-memory image loader.
module tb_imem_loader;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DEPTH  = 256;

   logic              clock;
   logic              reset_n;
   logic              start;
   logic              in_valid;
   logic [7:0]        in_byte;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              cpu_hold;
   logic              busy;
   logic              done;
   logic              err;

   int n_checks = 0;
   int n_errors = 0;

   // Observed writes, appended by the monitor only
   logic [ADDR_W-1:0] wa[$];
   logic [7:0]        wd[$];
   // Stimulus and expected image
   logic [7:0]        stream_q[$];
   logic [7:0]        data_q[$];

   imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .in_valid (in_valid),
      .in_byte  (in_byte),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Record every write strobe mid-cycle
   always @(negedge clock) begin
      if (wr_en) begin
         wa.push_back(wr_addr);
         wd.push_back(wr_data);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // {in_ready, busy, cpu_hold, done, err}
   function automatic logic [4:0] status();
      return {in_ready, busy, cpu_hold, done, err};
   endfunction

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   // Offer one byte and return just after the edge that accepts it
   task automatic send_byte(input logic [7:0] b);
      int t;
      t = 0;
      @(negedge clock);
      in_valid = 1'b1;
      in_byte  = b;
      while (!in_ready && t < 50) begin
         @(negedge clock);
         t++;
      end
      if (!in_ready) begin
         check("accept_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
      end else begin
         @(posedge clock);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic send_stream(input int first, input int last, input bit gaps);
      for (int i = first; i <= last; i++) begin
         if (gaps) begin
            int g;
            g = int'($urandom_range(0, 3));
            for (int k = 0; k < g; k++) @(negedge clock);
         end
         send_byte(stream_q[i]);
      end
   endtask

   task automatic build_stream(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] csum);
      stream_q.delete();
      stream_q.push_back(hi);
      stream_q.push_back(lo);
      foreach (data_q[i]) stream_q.push_back(data_q[i]);
      stream_q.push_back(csum);
   endtask

   task automatic check_writes(input string tag, input int base);
      check({tag, "_count"}, 32'(wa.size() - base), 32'(data_q.size()));
      for (int i = 0; i < data_q.size() && (base + i) < wa.size(); i++) begin
         check({tag, "_addr"}, 32'(wa[base+i]), 32'(i));
         check({tag, "_data"}, 32'(wd[base+i]), 32'(data_q[i]));
      end
   endtask

   task automatic load_nominal(input string tag, input logic [7:0] csum, input bit gaps);
      int base;
      data_q = {8'hF8, 8'h40, 8'h83, 8'hE1};
      build_stream(8'h00, 8'h04, csum);
      base = wa.size();
      pulse_start();
      check({tag, "_started"}, 32'(status()), 32'(5'b11100));
      send_stream(0, 5, gaps);
      check({tag, "_hold_pre_csum"}, 32'(status()), 32'(5'b11100));
      send_stream(6, 6, gaps);
      if (csum == 8'h64) check({tag, "_end"}, 32'(status()), 32'(5'b00010));
      else               check({tag, "_end"}, 32'(status()), 32'(5'b00101));
      check_writes(tag, base);
   endtask

   task automatic bad_length(input string tag, input logic [7:0] hi, input logic [7:0] lo);
      int base;
      data_q.delete();
      stream_q = {hi, lo};
      base = wa.size();
      pulse_start();
      send_stream(0, 1, 1'b0);
      check({tag, "_status"}, 32'(status()), 32'(5'b00101));
      @(negedge clock);
      check({tag, "_nowrite"}, 32'(wa.size() - base), 32'd0);
   endtask

   initial begin
      int          base;
      logic [7:0]  sum;
      logic [7:0]  b;

      reset_n  = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_byte  = 8'h00;
      #12;
      check("reset_status", 32'(status()), 32'd0);
      check("reset_write", {15'd0, wr_en, wr_addr, wr_data}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check("idle_status", 32'(status()), 32'd0);

      // Nominal image, then a corrupted checksum, then a clean restart
      load_nominal("nominal", 8'h64, 1'b0);
      load_nominal("bad_csum", 8'h65, 1'b0);
      load_nominal("restart", 8'h64, 1'b0);

      // Illegal lengths: not a multiple of 4, zero, beyond depth
      bad_length("len_6", 8'h00, 8'h06);
      bad_length("len_0", 8'h00, 8'h00);
      bad_length("len_260", 8'h01, 8'h04);

      // Full-depth image with random contents
      data_q.delete();
      sum = 8'h00;
      for (int i = 0; i < 256; i++) begin
         b = 8'($urandom);
         data_q.push_back(b);
         sum = 8'(sum + b);
      end
      build_stream(8'h01, 8'h00, 8'(8'h00 - sum));
      base = wa.size();
      pulse_start();
      send_stream(0, stream_q.size() - 1, 1'b0);
      check("full_end", 32'(status()), 32'(5'b00010));
      check_writes("full", base);

      // Same nominal image with random in_valid gaps
      load_nominal("gaps", 8'h64, 1'b1);

      // Stray start mid-session must be ignored
      data_q = {8'hF8, 8'h40, 8'h83, 8'hE1};
      build_stream(8'h00, 8'h04, 8'h64);
      base = wa.size();
      pulse_start();
      send_stream(0, 3, 1'b0);
      pulse_start();
      check("stray_start_status", 32'(status()), 32'(5'b11100));
      send_stream(4, 6, 1'b0);
      check("stray_start_end", 32'(status()), 32'(5'b00010));
      check_writes("stray_start", base);

      // Reset in the middle of the data phase
      data_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      build_stream(8'h00, 8'h08, 8'h00);
      pulse_start();
      send_stream(0, 3, 1'b0);
      reset_n = 1'b0;
      @(negedge clock);
      check("rst_mid_status", 32'(status()), 32'd0);
      check("rst_mid_write", {15'd0, wr_en, wr_addr, wr_data}, 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      check("rst_mid_idle", 32'(status()), 32'd0);

      load_nominal("post_reset", 8'h64, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that writes a length-prefixed, checksummed image into the byte-addressed instruction memory's write port. It sits between a host byte channel (UART or debug bridge) and the instruction memory. It holds the CPU in reset-stall while the image is in flight. Bytes are stored in arrival order at ascending addresses, so the host sends each 32-bit instruction most-significant byte first, matching the memory's big-endian fetch of four bytes from PC..PC+3.

## Interface
Parameters:
- ADDR_W, 8, byte-address width of instruction memory
- DEPTH, 256, memory size in bytes (must equal 2**ADDR_W)

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a load session
- in_valid  in  1  host byte valid
- in_byte  in  8  host byte
- in_ready  out  1  loader accepts byte this cycle
- wr_en  out  1  instruction-memory byte write strobe
- wr_addr  out  ADDR_W  byte address
- wr_data  out  8  byte to write
- cpu_hold  out  1  stall/hold CPU fetch
- busy  out  1  session in progress
- done  out  1  image loaded and checksum correct (level)
- err  out  1  session failed (level)

## Operation
- Byte accepted when in_valid && in_ready.
- Stream format after start: LEN_HI, LEN_LO (16-bit byte count N), N data bytes, 1 checksum byte C.
- Valid image: (sum of data bytes + C) mod 256 == 0.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
  - IDLE/DONE/ERR: start -> LEN_HI, and clear the address counter, checksum accumulator, done and err. start in any other state is ignored.
  - LEN_HI: on accept, latch the high byte -> LEN_LO.
  - LEN_LO: on accept, latch the low byte.
    - If N == 0, N mod 4 != 0, or N > DEPTH -> ERR.
    - Otherwise -> DATA.
  - DATA: on accept, write the byte at the address counter, add it to the accumulator, increment the counter. After the N-th byte -> CSUM.
  - CSUM: on accept, if (acc + C) mod 256 == 0 -> DONE, else -> ERR.
- in_ready = 1 only in LEN_HI, LEN_LO, DATA, CSUM.
- cpu_hold = 1 in every state except IDLE and DONE. It stays 1 in ERR so a partial image never runs.
- busy = 1 in LEN_HI..CSUM.
- Only DATA-state bytes generate writes. Header and checksum bytes never write.
- Address counter is ADDR_W+1 bits internally. wr_addr is its low ADDR_W bits. With N == DEPTH the last write hits DEPTH-1, with no wrap to 0.

## Timing
- Reset values: state IDLE, in_ready 0, wr_en 0, wr_addr 0, wr_data 0, cpu_hold 0, busy 0, done 0, err 0.
- Reset asserted mid-session aborts immediately to IDLE. Memory contents are left as written.
- Write latency is one cycle. The byte accepted at edge k appears as wr_en=1 with wr_addr/wr_data registered during cycle k+1. wr_en is a single-cycle pulse per accepted data byte.
- Back-to-back accepts give consecutive wr_en pulses. An in_valid gap produces no write.
- State outputs (in_ready, busy, cpu_hold, done, err) are registered from state and change the cycle after the deciding accept.
- cpu_hold rises the cycle after start and falls the cycle after the checksum accept that enters DONE.
- No combinational path from in_valid to in_ready.

## Structure
- A shared package holds:
  - the state enum
  - header length constant (2 bytes) and checksum length (1 byte)
  - the instruction-width constant (4 bytes/instruction) used by the N mod 4 check
- Single module; no sub-module. The checksum accumulator and address counter are inline registers.

## Test plan
- Nominal load: start; bytes 00 04 F8 40 83 E1 64 -> writes (0,F8)(1,40)(2,83)(3,E1), done=1, err=0, cpu_hold falls after 64 accepted.
- Bad checksum: same stream with final byte 65 -> four writes occur, err=1, done=0, cpu_hold stays 1. A new start then restarts cleanly.
- Illegal length: 00 06 -> ERR right after LEN_LO, in_ready=0, zero writes. Repeat with 00 00 and 01 04, each -> ERR.
- Full-depth image: N=0x0100 with 256 random bytes and correct checksum -> 256 writes, addresses 0x00..0xFF in order, no wrap, done=1.
- Backpressure: randomised in_valid gaps during the nominal stream -> exactly one wr_en per data byte, same address/data sequence as the nominal case.
- Reset mid-DATA: assert reset_n=0 after the second data byte -> all outputs at reset values next cycle. Stray start pulses during busy are ignored, with no restart.
